// File: rtl/hazard_detection_unit.sv
// Pipeline hazard detection: branch flush, scalar load-use stall and multi-cycle vector load stall.
// Optional HAZARD_STATS_EN adds a saturating stall-cycle counter with synchronous clear.
module hazard_detection_unit #(
    parameter int unsigned VEC_LOAD_STALL = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rs1_decode,
    input  logic [4:0] rs2_decode,
    input  logic [4:0] rd_execute,
    input  logic       read_memory_enable_execute,
    input  logic       vector_load_execute,
    input  logic       branch_taken_execute,
`ifdef HAZARD_STATS_EN
    input  logic       stats_clear,
    output logic [15:0] stall_cycle_count,
`endif
    output logic       stall_fetch,
    output logic       stall_decode,
    output logic       flush_decode,
    output logic       flush_execute,
    output logic       busy
);

    typedef enum logic [0:0] {StIdle, StVecStall} state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       match;

    assign match = (rd_execute == rs1_decode) || (rd_execute == rs2_decode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (!branch_taken_execute && vector_load_execute && match
                    && (VEC_LOAD_STALL > 1)) begin
                    state_d = StVecStall;
                    cnt_d   = 4'(VEC_LOAD_STALL - 1);
                end
            end
            StVecStall: begin
                // Execute holds a bubble here, so its inputs cannot re-trigger or reload.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        stall_fetch   = 1'b0;
        stall_decode  = 1'b0;
        flush_decode  = 1'b0;
        flush_execute = 1'b0;
        busy          = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (branch_taken_execute) begin
                    flush_decode  = 1'b1;
                    flush_execute = 1'b1;
                end else if ((vector_load_execute || read_memory_enable_execute) && match) begin
                    stall_fetch   = 1'b1;
                    stall_decode  = 1'b1;
                    flush_execute = 1'b1;
                end
            end
            StVecStall: begin
                stall_fetch   = 1'b1;
                stall_decode  = 1'b1;
                flush_execute = 1'b1;
                busy          = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycle_count <= 16'd0;
        end else if (stats_clear) begin
            stall_cycle_count <= 16'd0;
        end else if (stall_decode && (stall_cycle_count != 16'hFFFF)) begin
            stall_cycle_count <= stall_cycle_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench for hazard_detection_unit; three instances cover VEC_LOAD_STALL = 3, 5 and 1.
// Output vectors are packed as {stall_fetch, stall_decode, flush_decode, flush_execute, busy}.
module tb_hazard_detection_unit;

    logic       clk;
    logic       rst_n;
    logic [4:0] rs1_decode;
    logic [4:0] rs2_decode;
    logic [4:0] rd_execute;
    logic       rme;
    logic       vle;
    logic       bte;
    logic       stats_clear;

    logic sf3, sd3, fd3, fe3, busy3;
    logic sf5, sd5, fd5, fe5, busy5;
    logic sf1, sd1, fd1, fe1, busy1;
    logic [15:0] cnt3, cnt5, cnt1;

    int total = 0;
    int bad   = 0;

    wire [4:0] o3 = {sf3, sd3, fd3, fe3, busy3};
    wire [4:0] o5 = {sf5, sd5, fd5, fe5, busy5};
    wire [4:0] o1 = {sf1, sd1, fd1, fe1, busy1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hazard_detection_unit #(.VEC_LOAD_STALL(3)) u3 (
        .clk(clk), .rst_n(rst_n), .rs1_decode(rs1_decode), .rs2_decode(rs2_decode),
        .rd_execute(rd_execute), .read_memory_enable_execute(rme),
        .vector_load_execute(vle), .branch_taken_execute(bte),
`ifdef HAZARD_STATS_EN
        .stats_clear(stats_clear), .stall_cycle_count(cnt3),
`endif
        .stall_fetch(sf3), .stall_decode(sd3), .flush_decode(fd3), .flush_execute(fe3),
        .busy(busy3)
    );

    hazard_detection_unit #(.VEC_LOAD_STALL(5)) u5 (
        .clk(clk), .rst_n(rst_n), .rs1_decode(rs1_decode), .rs2_decode(rs2_decode),
        .rd_execute(rd_execute), .read_memory_enable_execute(rme),
        .vector_load_execute(vle), .branch_taken_execute(bte),
`ifdef HAZARD_STATS_EN
        .stats_clear(stats_clear), .stall_cycle_count(cnt5),
`endif
        .stall_fetch(sf5), .stall_decode(sd5), .flush_decode(fd5), .flush_execute(fe5),
        .busy(busy5)
    );

    hazard_detection_unit #(.VEC_LOAD_STALL(1)) u1 (
        .clk(clk), .rst_n(rst_n), .rs1_decode(rs1_decode), .rs2_decode(rs2_decode),
        .rd_execute(rd_execute), .read_memory_enable_execute(rme),
        .vector_load_execute(vle), .branch_taken_execute(bte),
`ifdef HAZARD_STATS_EN
        .stats_clear(stats_clear), .stall_cycle_count(cnt1),
`endif
        .stall_fetch(sf1), .stall_decode(sd1), .flush_decode(fd1), .flush_execute(fe1),
        .busy(busy1)
    );

    task automatic set_in(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                          input logic l, input logic v, input logic b);
        rd_execute = rd;
        rs1_decode = r1;
        rs2_decode = r2;
        rme        = l;
        vle        = v;
        bte        = b;
    endtask

    // Advance to the next negedge (one posedge elapses), then apply inputs and settle.
    task automatic cycle(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                         input logic l, input logic v, input logic b);
        @(negedge clk);
        set_in(rd, r1, r2, l, v, b);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_in(5'd3, 5'd4, 5'd6, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stats_clear = 1'b0;
        set_in(5'd3, 5'd4, 5'd6, 1'b0, 1'b0, 1'b0);
        #1;
        total++;
        if ({o3, o5, o1} !== 15'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=0", {o3, o5, o1});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_no_match();
        apply_reset();
        set_in(5'd3, 5'd4, 5'd6, 1'b1, 1'b1, 1'b0);
        #1;
        total++;
        if (o3 !== 5'b00000 || o1 !== 5'b00000) begin
            bad++;
            $display("FAIL no_match got3=%b got1=%b exp=00000", o3, o1);
        end
    endtask

    task automatic test_scalar();
        apply_reset();
        set_in(5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0);
        #1;
        total++;
        if (o3 !== 5'b11010) begin
            bad++;
            $display("FAIL scalar_stall got=%b exp=11010", o3);
        end
        cycle(5'd5, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        total++;
        if (o3 !== 5'b00000) begin
            bad++;
            $display("FAIL scalar_release got=%b exp=00000", o3);
        end
        // Register 0 gets no special treatment.
        cycle(5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
        total++;
        if (o3 !== 5'b11010) begin
            bad++;
            $display("FAIL scalar_x0 got=%b exp=11010", o3);
        end
    endtask

    task automatic test_branch();
        apply_reset();
        set_in(5'd5, 5'd5, 5'd2, 1'b1, 1'b0, 1'b1);
        #1;
        total++;
        if (o3 !== 5'b00110) begin
            bad++;
            $display("FAIL branch_over_load got=%b exp=00110", o3);
        end
        cycle(5'd5, 5'd5, 5'd2, 1'b0, 1'b1, 1'b1);
        total++;
        if (o3 !== 5'b00110) begin
            bad++;
            $display("FAIL branch_over_vec got=%b exp=00110", o3);
        end
        cycle(5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        total++;
        if (o3 !== 5'b00000) begin
            bad++;
            $display("FAIL branch_no_residue got=%b exp=00000", o3);
        end
    endtask

    task automatic test_vector3();
        logic [4:0] exp_seq [4] = '{5'b11010, 5'b11011, 5'b11011, 5'b00000};
        apply_reset();
        set_in(5'd7, 5'd7, 5'd1, 1'b0, 1'b1, 1'b0);
        #1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (o3 !== exp_seq[i]) begin
                bad++;
                $display("FAIL vec3_cycle%0d got=%b exp=%b", i + 1, o3, exp_seq[i]);
            end
            // Keep hazard and a branch active during the stall; both must be ignored.
            if (i == 0) cycle(5'd7, 5'd7, 5'd1, 1'b1, 1'b1, 1'b1);
            else if (i == 1) cycle(5'd7, 5'd7, 5'd1, 1'b0, 1'b1, 1'b0);
            else if (i == 2) cycle(5'd7, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_priority();
        apply_reset();
        set_in(5'd9, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0);
        #1;
        cycle(5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        total++;
        if (o3 !== 5'b11011) begin
            bad++;
            $display("FAIL both_loads_vector got=%b exp=11011", o3);
        end
    endtask

    task automatic test_vec1();
        apply_reset();
        set_in(5'd7, 5'd7, 5'd1, 1'b0, 1'b1, 1'b0);
        #1;
        total++;
        if (o1 !== 5'b11010) begin
            bad++;
            $display("FAIL vec1_stall got=%b exp=11010", o1);
        end
        cycle(5'd7, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        total++;
        if (o1 !== 5'b00000) begin
            bad++;
            $display("FAIL vec1_single got=%b exp=00000", o1);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_in(5'd7, 5'd7, 5'd1, 1'b0, 1'b1, 1'b0);
        #1;
        cycle(5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        total++;
        if (o5 !== 5'b11011) begin
            bad++;
            $display("FAIL vec5_second got=%b exp=11011", o5);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (o5 !== 5'b00000) begin
            bad++;
            $display("FAIL vec5_async_reset got=%b exp=00000", o5);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (o5 !== 5'b00000) begin
            bad++;
            $display("FAIL vec5_release got=%b exp=00000", o5);
        end
        cycle(5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        total++;
        if (o5 !== 5'b00000) begin
            bad++;
            $display("FAIL vec5_no_residue got=%b exp=00000", o5);
        end
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        apply_reset();
        total++;
        if (cnt3 !== 16'd0) begin
            bad++;
            $display("FAIL stats_reset got=%h exp=0000", cnt3);
        end
        set_in(5'd5, 5'd5, 5'd1, 1'b1, 1'b0, 1'b0);
        repeat (65534) @(negedge clk);
        total++;
        if (cnt3 !== 16'hFFFE) begin
            bad++;
            $display("FAIL stats_preload got=%h exp=fffe", cnt3);
        end
        set_in(5'd7, 5'd7, 5'd1, 1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        set_in(5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        #1;
        total++;
        if (cnt3 !== 16'hFFFF) begin
            bad++;
            $display("FAIL stats_saturate got=%h exp=ffff", cnt3);
        end
        @(negedge clk);
        total++;
        if (cnt3 !== 16'hFFFF) begin
            bad++;
            $display("FAIL stats_hold got=%h exp=ffff", cnt3);
        end
        stats_clear = 1'b1;
        set_in(5'd5, 5'd5, 5'd1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        stats_clear = 1'b0;
        set_in(5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        #1;
        total++;
        if (cnt3 !== 16'd0) begin
            bad++;
            $display("FAIL stats_clear got=%h exp=0000", cnt3);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_no_match();
        test_scalar();
        test_branch();
        test_vector3();
        test_priority();
        test_vec1();
        test_reset_mid();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_detection_unit.md
HAZARD_DETECTION_UNIT -- requirements
Module: hazard_detection_unit

Interface
REQ-001 SHALL have parameter VEC_LOAD_STALL, default 3: total stall cycles for a vector load-use hazard; legal range 1..15.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports rs1_decode, rs2_decode  input  5 each  source registers of the instruction in decode.
REQ-005 SHALL have port rd_execute  input  5  destination register of the instruction in execute.
REQ-006 SHALL have port read_memory_enable_execute  input  1  execute instruction is a scalar load.
REQ-007 SHALL have port vector_load_execute  input  1  execute instruction is a vector load.
REQ-008 SHALL have port branch_taken_execute  input  1  branch resolved taken in execute.
REQ-009 SHALL have ports stall_fetch, stall_decode  output  1 each  hold PC and the IF/ID register.
REQ-010 SHALL have ports flush_decode, flush_execute  output  1 each  zero IF/ID and ID/EX control, inserting a bubble.
REQ-011 SHALL have port busy  output  1  FSM in VEC_STALL.

Function
REQ-012 SHALL define match as (rd_execute==rs1_decode) OR (rd_execute==rs2_decode); no register is exempt.
REQ-013 SHALL implement FSM states IDLE and VEC_STALL, plus a 4-bit down-counter cnt.
REQ-014 In IDLE, SHALL assert flush_decode and flush_execute combinationally in the same cycle when branch_taken_execute=1; stalls stay 0; state stays IDLE.
REQ-015 In IDLE without branch, SHALL treat read_memory_enable_execute AND match as a scalar hazard: stall_fetch=stall_decode=flush_execute=1 for that cycle only; state stays IDLE.
REQ-016 In IDLE without branch, SHALL treat vector_load_execute AND match as a vector hazard: assert stall_fetch, stall_decode and flush_execute that cycle.
REQ-017 On a vector hazard, SHALL load cnt with VEC_LOAD_STALL-1 and enter VEC_STALL if VEC_LOAD_STALL>1; otherwise SHALL stay in IDLE.
REQ-018 In VEC_STALL, SHALL assert stall_fetch, stall_decode and flush_execute every cycle and decrement cnt each cycle.
REQ-019 SHALL return from VEC_STALL to IDLE on the edge where cnt==1, so total stall cycles equal VEC_LOAD_STALL.
REQ-020 Priority in IDLE SHALL be branch > vector hazard > scalar hazard; when both load flags are set, the vector rule applies.
REQ-021 In VEC_STALL, SHALL ignore all execute-stage inputs (execute holds a bubble); no re-trigger and no cnt reload.
REQ-022 Outputs SHALL be pure functions of state, cnt and current inputs; no extra latency is added beyond REQ-014..019.
REQ-023 SHALL drive busy=1 exactly when state is VEC_STALL.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE and cnt=0, and, with inputs idle, all outputs to 0, independent of clk.
REQ-025 Reset asserted mid-VEC_STALL SHALL abort the stall; after release, the FSM re-evaluates inputs from IDLE.
REQ-026 The first rising edge after rst_n rises SHALL be a normal IDLE cycle.

Configuration
REQ-027 Macro HAZARD_STATS_EN, when defined, SHALL add input stats_clear (1 bit) and output stall_cycle_count (16 bits).
REQ-028 With HAZARD_STATS_EN, stall_cycle_count SHALL increment on every edge where stall_decode=1, saturate at 0xFFFF, and clear to 0 on stats_clear=1 (clear wins) or reset.
REQ-029 Without HAZARD_STATS_EN, both ports and the counter SHALL be absent; all other behaviour is identical.

Verification
REQ-030 Scalar: read_memory_enable_execute=1, rd_execute=5, rs2_decode=5 -> stall_fetch/stall_decode/flush_execute=1 for 1 cycle; busy stays 0.
REQ-031 Vector, VEC_LOAD_STALL=3: vector_load_execute=1, rd_execute=7, rs1_decode=7 -> stalls high 3 consecutive cycles, busy high for cycles 2-3, then all 0.
REQ-032 Branch with load match: branch_taken_execute=1, read_memory_enable_execute=1, match true -> flush_decode=flush_execute=1, stalls 0.
REQ-033 Reset mid-stall: VEC_LOAD_STALL=5, drop rst_n in the 2nd stall cycle -> all outputs 0 immediately, busy=0; no residual stall after release.
REQ-034 Boundary: VEC_LOAD_STALL=1 with vector hazard -> exactly 1 stall cycle and busy never asserts; no match (rd_execute=3, rs=4,6) -> no outputs.
REQ-035 Stats (HAZARD_STATS_EN): preload stall_cycle_count to 0xFFFE, then a 3-cycle vector stall -> 0xFFFF, held; stats_clear=1 -> 0.
